// File: rtl/adc_capture_ctrl_pkg.sv
// Shared types and encodings for the ADC capture sequencer and its
// trigger qualifier.
package adc_capture_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRE       = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_CAPTURE   = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  localparam logic [1:0] TRIG_RISE = 2'b00;
  localparam logic [1:0] TRIG_FALL = 2'b01;
  localparam logic [1:0] TRIG_HIGH = 2'b10;
  localparam logic [1:0] TRIG_LOW  = 2'b11;

endpackage

// File: rtl/adc_capture_ctrl_if.sv
// Control/status bundle between the capture sequencer (slave) and the
// register block / datapath side that drives it (master).
interface adc_capture_ctrl_if
  import adc_capture_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = 32,
  parameter int PRE_WIDTH = 16
);
  // Handshake: arm and abort are single-cycle pulses sampled on the rising
  // edge of adc_sampleclk; every status output is registered and valid on
  // every cycle, with no acknowledge in either direction.
  logic                 arm;
  logic                 abort;
  logic                 trig_in;
  logic [1:0]           trig_mode;
  logic [PRE_WIDTH-1:0] pretrig_samples;
  logic [CNT_WIDTH-1:0] total_samples;
  logic                 fifo_full;
  logic                 dp_stop;
  logic                 capture_go;
  logic                 trig_status;
  logic                 busy;
  logic                 done;
  logic                 overflow;
  logic [CNT_WIDTH-1:0] samples_captured;
  logic [CNT_WIDTH-1:0] trig_index;
  state_t               dbg_state;

  modport master (
    output arm, abort, trig_in, trig_mode, pretrig_samples, total_samples,
           fifo_full, dp_stop,
    input  capture_go, trig_status, busy, done, overflow, samples_captured,
           trig_index, dbg_state
  );

  modport slave (
    input  arm, abort, trig_in, trig_mode, pretrig_samples, total_samples,
           fifo_full, dp_stop,
    output capture_go, trig_status, busy, done, overflow, samples_captured,
           trig_index, dbg_state
  );
endinterface

// File: rtl/adc_capture_ctrl_trig_qualifier.sv
// Brings the asynchronous trigger into adc_sampleclk and qualifies it as an
// edge (one-cycle hit) or level (held hit) according to trig_mode.
module adc_capture_ctrl_trig_qualifier
  import adc_capture_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       adc_sampleclk,
  input  logic       ddr_usrreset,
  input  logic       i_trig_in,
  input  logic [1:0] i_trig_mode,
  output logic       o_trig_hit
);
  // A single flop is never an adequate synchronizer.
  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [SYNC_N-1:0] r_sync;
  logic              r_hist;
  logic              w_sync;

  assign w_sync = r_sync[SYNC_N-1];

  always_ff @(posedge adc_sampleclk or posedge ddr_usrreset) begin
    if (ddr_usrreset) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_N-2:0], i_trig_in};
      r_hist <= w_sync;
    end
  end

  always_comb begin
    o_trig_hit = 1'b0;
    case (i_trig_mode)
      TRIG_RISE: o_trig_hit = w_sync & ~r_hist;
      TRIG_FALL: o_trig_hit = ~w_sync & r_hist;
      TRIG_HIGH: o_trig_hit = w_sync;
      TRIG_LOW:  o_trig_hit = ~w_sync;
      default:   o_trig_hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Capture sequencer for the ADC-to-DDR write path: arm, pre-trigger fill,
// trigger wait, post-trigger capture, with sticky done/overflow status.
module adc_capture_ctrl
  import adc_capture_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH   = 32,
  parameter int PRE_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic               adc_sampleclk,
  input logic               ddr_usrreset,
  adc_capture_ctrl_if.slave io_ctrl
);
  // One extra bit keeps samples+1 from wrapping onto a zero compare value.
  localparam int CW1 = CNT_WIDTH + 1;

  state_t               r_state;
  logic [PRE_WIDTH-1:0] r_pretrig;
  logic [CNT_WIDTH-1:0] r_total;
  logic [CNT_WIDTH-1:0] r_samples;
  logic [CNT_WIDTH-1:0] r_trig_index;
  logic                 r_capture_go;
  logic                 r_trig_status;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_overflow;

  logic                 w_trig_hit;
  logic                 w_overflow;
  logic                 w_total_hit;
  logic                 w_pre_hit;
  logic                 w_finish;
  logic [CW1-1:0]       w_cnt_plus1;
  logic [CNT_WIDTH-1:0] w_samples_next;

  adc_capture_ctrl_trig_qualifier #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_trig_qual (
    .adc_sampleclk (adc_sampleclk),
    .ddr_usrreset  (ddr_usrreset),
    .i_trig_in     (io_ctrl.trig_in),
    .i_trig_mode   (io_ctrl.trig_mode),
    .o_trig_hit    (w_trig_hit)
  );

  assign w_cnt_plus1    = {1'b0, r_samples} + CW1'(1);
  assign w_samples_next = (&r_samples) ? r_samples : w_cnt_plus1[CNT_WIDTH-1:0];
  assign w_overflow     = io_ctrl.fifo_full & r_capture_go;
  assign w_total_hit    = (w_cnt_plus1 == {1'b0, r_total});
  assign w_pre_hit      = (w_cnt_plus1 == CW1'(r_pretrig));
  // Stop sources in priority order below abort; dp_stop ends any active phase.
  assign w_finish       = w_overflow | io_ctrl.dp_stop | w_total_hit;

  always_ff @(posedge adc_sampleclk or posedge ddr_usrreset) begin
    if (ddr_usrreset) begin
      r_state       <= ST_IDLE;
      r_pretrig     <= '0;
      r_total       <= '0;
      r_samples     <= '0;
      r_trig_index  <= '0;
      r_capture_go  <= 1'b0;
      r_trig_status <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (io_ctrl.arm) begin
            r_pretrig     <= io_ctrl.pretrig_samples;
            r_total       <= io_ctrl.total_samples;
            r_samples     <= '0;
            r_trig_index  <= '0;
            r_trig_status <= 1'b0;
            r_overflow    <= 1'b0;
            if (io_ctrl.total_samples == '0) begin
              r_state      <= ST_DONE;
              r_done       <= 1'b1;
              r_capture_go <= 1'b0;
              r_busy       <= 1'b0;
            end else begin
              r_state      <= (io_ctrl.pretrig_samples == '0) ? ST_WAIT_TRIG : ST_PRE;
              r_done       <= 1'b0;
              r_capture_go <= 1'b1;
              r_busy       <= 1'b1;
            end
          end
        end

        ST_PRE, ST_WAIT_TRIG, ST_CAPTURE: begin
          if (io_ctrl.abort) begin
            // Counters freeze so software can see how far the capture got.
            r_state       <= ST_IDLE;
            r_capture_go  <= 1'b0;
            r_trig_status <= 1'b0;
            r_busy        <= 1'b0;
          end else begin
            r_samples <= w_samples_next;
            if (w_finish) begin
              r_state       <= ST_DONE;
              r_capture_go  <= 1'b0;
              r_trig_status <= 1'b0;
              r_busy        <= 1'b0;
              r_done        <= 1'b1;
              r_overflow    <= w_overflow;
            end else if (r_state == ST_PRE) begin
              if (w_pre_hit) begin
                r_state <= ST_WAIT_TRIG;
              end
            end else if ((r_state == ST_WAIT_TRIG) && w_trig_hit) begin
              r_trig_index  <= r_samples;
              r_trig_status <= 1'b1;
              r_state       <= ST_CAPTURE;
            end
          end
        end

        default: begin
          r_state       <= ST_IDLE;
          r_capture_go  <= 1'b0;
          r_trig_status <= 1'b0;
          r_busy        <= 1'b0;
        end
      endcase
    end
  end

  assign io_ctrl.capture_go       = r_capture_go;
  assign io_ctrl.trig_status      = r_trig_status;
  assign io_ctrl.busy             = r_busy;
  assign io_ctrl.done             = r_done;
  assign io_ctrl.overflow         = r_overflow;
  assign io_ctrl.samples_captured = r_samples;
  assign io_ctrl.trig_index       = r_trig_index;
  assign io_ctrl.dbg_state        = r_state;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed scoreboard bench for adc_capture_ctrl: each capture pushes its
// expected end-of-capture status; a monitor pops it when the FSM settles.
module tb_adc_capture_ctrl;
  import adc_capture_ctrl_pkg::*;

  localparam int SS = 2;
  localparam int CW = 32;

  typedef struct packed {
    logic [2:0]  state;
    logic        done;
    logic        overflow;
    logic [31:0] samples;
    logic [31:0] trig_index;
    logic [31:0] go_cycles;
    logic [31:0] ts_cycles;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  logic adc_sampleclk = 1'b0;
  logic ddr_usrreset  = 1'b1;

  adc_capture_ctrl_if #(.CNT_WIDTH(CW), .PRE_WIDTH(16)) io ();

  adc_capture_ctrl #(
    .CNT_WIDTH   (CW),
    .PRE_WIDTH   (16),
    .SYNC_STAGES (SS)
  ) dut (
    .adc_sampleclk (adc_sampleclk),
    .ddr_usrreset  (ddr_usrreset),
    .io_ctrl       (io)
  );

  // ---------------- clock / reset ----------------
  always #5 adc_sampleclk = ~adc_sampleclk;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];
  int checks   = 0;
  int errors   = 0;
  int ev_count = 0;
  int ev_start = 0;
  int rel      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input state_t st, input logic dn, input logic ov,
                          input int samples, input int idx, input int go, input int ts);
    exp_t e;
    e.state      = st;
    e.done       = dn;
    e.overflow   = ov;
    e.samples    = 32'(samples);
    e.trig_index = 32'(idx);
    e.go_cycles  = 32'(go);
    e.ts_cycles  = 32'(ts);
    exp_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  // An "output" is the FSM settling into DONE or IDLE from another state.
  initial begin : monitor
    state_t prev_state;
    int     go_cnt;
    int     ts_cnt;
    exp_t   e;
    prev_state = ST_IDLE;
    go_cnt     = 0;
    ts_cnt     = 0;
    forever begin
      @(negedge adc_sampleclk);
      if (ddr_usrreset) begin
        prev_state = ST_IDLE;
        go_cnt     = 0;
        ts_cnt     = 0;
      end else begin
        if (io.capture_go)  go_cnt++;
        if (io.trig_status) ts_cnt++;
        if ((io.dbg_state != prev_state) &&
            ((io.dbg_state == ST_DONE) || (io.dbg_state == ST_IDLE))) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_end: state %0d with no expected entry", io.dbg_state);
          end else begin
            e = exp_q.pop_front();
            chk("end_state",   32'(io.dbg_state),   32'(e.state));
            chk("done",        32'(io.done),        32'(e.done));
            chk("overflow",    32'(io.overflow),    32'(e.overflow));
            chk("busy_low",    32'(io.busy),        32'd0);
            chk("go_low",      32'(io.capture_go),  32'd0);
            chk("ts_low",      32'(io.trig_status), 32'd0);
            chk("samples",     io.samples_captured, e.samples);
            chk("trig_index",  io.trig_index,       e.trig_index);
            chk("go_cycles",   32'(go_cnt),         e.go_cycles);
            chk("ts_cycles",   32'(ts_cnt),         e.ts_cycles);
          end
          go_cnt = 0;
          ts_cnt = 0;
          ev_count++;
        end
        prev_state = io.dbg_state;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge adc_sampleclk);
  endtask

  // Arm is sampled on edge e0; afterwards inputs driven now are seen at e1.
  task automatic start_capture(input logic [1:0] mode, input int pre, input int total);
    ev_start = ev_count;
    io.trig_mode       = mode;
    io.pretrig_samples = 16'(pre);
    io.total_samples   = 32'(total);
    @(negedge adc_sampleclk);
    io.arm = 1'b1;
    @(negedge adc_sampleclk);
    io.arm = 1'b0;
    rel = 1;
  endtask

  // Advance so that inputs driven next are sampled on edge e<n>.
  task automatic at_slot(input int n);
    repeat (n - rel) @(negedge adc_sampleclk);
    rel = n;
  endtask

  task automatic wait_end(input string name, input int budget);
    int n;
    n = 0;
    while ((ev_count == ev_start) && (n < budget)) begin
      @(negedge adc_sampleclk);
      #1;
      n++;
    end
    if (ev_count == ev_start) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no capture end after %0d cycles, expected one", name, budget);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    io.arm             = 1'b0;
    io.abort           = 1'b0;
    io.trig_in         = 1'b0;
    io.trig_mode       = TRIG_RISE;
    io.pretrig_samples = '0;
    io.total_samples   = '0;
    io.fifo_full       = 1'b0;
    io.dp_stop         = 1'b0;

    idle(3);
    ddr_usrreset = 1'b0;
    idle(1);
    chk("rst_state",       32'(io.dbg_state),   32'(ST_IDLE));
    chk("rst_capture_go",  32'(io.capture_go),  32'd0);
    chk("rst_trig_status", 32'(io.trig_status), 32'd0);
    chk("rst_busy",        32'(io.busy),        32'd0);
    chk("rst_done",        32'(io.done),        32'd0);
    chk("rst_overflow",    32'(io.overflow),    32'd0);
    chk("rst_samples",     io.samples_captured, 32'd0);
    chk("rst_trig_index",  io.trig_index,       32'd0);

    // total=0: straight to DONE, capture_go never rises.
    push_exp(ST_DONE, 1'b1, 1'b0, 0, 0, 0, 0);
    start_capture(TRIG_RISE, 4, 0);
    wait_end("total_zero", 20);
    idle(3);

    // Trigger seen at e40 is acted on at e40+SS, index = count before that edge.
    // A stray arm at e50 must be ignored.
    push_exp(ST_DONE, 1'b1, 1'b0, 100, 40 + SS - 1, 100, 100 - (40 + SS - 1) - 1);
    start_capture(TRIG_RISE, 10, 100);
    at_slot(40); io.trig_in = 1'b1;
    at_slot(50); io.arm     = 1'b1;
    at_slot(51); io.arm     = 1'b0;
    wait_end("rise_basic", 200);
    io.trig_in = 1'b0;
    idle(5);

    // Pulse during the pre-trigger window is ignored; the edge at e30 counts.
    push_exp(ST_DONE, 1'b1, 1'b0, 60, 30 + SS - 1, 60, 60 - (30 + SS - 1) - 1);
    start_capture(TRIG_RISE, 10, 60);
    at_slot(5);  io.trig_in = 1'b1;
    at_slot(6);  io.trig_in = 1'b0;
    at_slot(30); io.trig_in = 1'b1;
    wait_end("pre_ignore", 200);
    io.trig_in = 1'b1;
    idle(5);

    // Falling trigger at e12, then fifo_full at e20 forces DONE with overflow.
    push_exp(ST_DONE, 1'b1, 1'b1, 20, 12 + SS - 1, 20, 20 - (12 + SS - 1) - 1);
    start_capture(TRIG_FALL, 10, 50);
    at_slot(12); io.trig_in   = 1'b0;
    at_slot(20); io.fifo_full = 1'b1;
    at_slot(21); io.fifo_full = 1'b0;
    wait_end("overflow", 100);
    io.trig_in = 1'b1;
    idle(5);

    // High level already present, pretrig=0: trigger accepted at e1 with
    // index 0; dp_stop at e30 ends the capture.
    push_exp(ST_DONE, 1'b1, 1'b0, 30, 0, 30, 29);
    start_capture(TRIG_HIGH, 0, 1000);
    at_slot(30); io.dp_stop = 1'b1;
    at_slot(31); io.dp_stop = 1'b0;
    wait_end("dp_stop", 100);
    io.trig_in = 1'b0;
    idle(5);

    // Abort at e15 during trigger wait: counters freeze at 14.
    push_exp(ST_IDLE, 1'b0, 1'b0, 14, 0, 15, 0);
    start_capture(TRIG_RISE, 10, 100);
    at_slot(15); io.abort = 1'b1;
    at_slot(16); io.abort = 1'b0;
    wait_end("abort", 100);
    io.trig_in = 1'b1;
    idle(5);

    // Re-arm after abort clears the counters; level trigger accepted at e4.
    push_exp(ST_DONE, 1'b1, 1'b0, 8, 3, 8, 4);
    start_capture(TRIG_HIGH, 3, 8);
    chk("rearm_samples_clear", io.samples_captured, 32'd0);
    chk("rearm_busy",          32'(io.busy),        32'd1);
    chk("rearm_capture_go",    32'(io.capture_go),  32'd1);
    wait_end("rearm", 50);
    idle(3);

    // total <= pretrig: ends in PRE after 5 samples, level trigger ignored.
    push_exp(ST_DONE, 1'b1, 1'b0, 5, 0, 5, 0);
    start_capture(TRIG_HIGH, 8, 5);
    wait_end("short_total", 50);
    io.trig_in = 1'b0;
    idle(3);

    // Reset mid-capture drops capture_go without waiting for a clock edge.
    start_capture(TRIG_RISE, 10, 100);
    at_slot(20);
    #2;
    ddr_usrreset = 1'b1;
    #1;
    chk("rst_mid_capture_go", 32'(io.capture_go), 32'd0);
    chk("rst_mid_busy",       32'(io.busy),       32'd0);
    chk("rst_mid_samples",    io.samples_captured, 32'd0);
    idle(2);
    ddr_usrreset = 1'b0;
    idle(2);
    chk("rst_mid_state", 32'(io.dbg_state), 32'(ST_IDLE));

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
Sequences one ADC capture in the adc_sampleclk domain. It arms on request, fills a programmable pre-trigger window, then waits for a qualified external trigger. It captures a programmed total sample count and reports status. It drives the capture-enable and trigger-tag inputs of the ADC-to-DDR write datapath, and watches that path's FIFO-full and stop indications.

Parameters:
CNT_WIDTH, 32, width of sample counters and total_samples
PRE_WIDTH, 16, width of pretrig_samples
SYNC_STAGES, 2, synchronizer depth for trig_in (minimum 2)

Ports:
adc_sampleclk  in  1  sample clock; all logic on rising edge
ddr_usrreset  in  1  asynchronous active-high reset
arm  in  1  single-cycle pulse; starts a capture
abort  in  1  single-cycle pulse; cancels the capture
trig_in  in  1  external trigger; asynchronous
trig_mode  in  2  00 rising, 01 falling, 10 high level, 11 low level
pretrig_samples  in  PRE_WIDTH  samples recorded before trigger is accepted
total_samples  in  CNT_WIDTH  total samples per capture, pre-trigger included
fifo_full  in  1  ADC FIFO full, from the datapath
dp_stop  in  1  datapath stop request (capacity reached)
capture_go  out  1  datapath enable; held high for the whole capture
trig_status  out  1  trigger tag; high from the trigger sample until capture end
busy  out  1  state not IDLE/DONE
done  out  1  sticky; capture finished
overflow  out  1  sticky; fifo_full seen while capture_go was high
samples_captured  out  CNT_WIDTH  samples taken in the current or last capture
trig_index  out  CNT_WIDTH  value of samples_captured at the trigger

Behaviour:
- Reset: state IDLE. All outputs 0; all counters 0; synchronizer flops 0.
- trig_in passes through SYNC_STAGES flops, then one history flop for edge detection.
- Edge modes: qualified when sync=1 and hist=0 (rising), or sync=0 and hist=1 (falling).
- Level modes: qualified on the synchronized value. Latency from trig_in to qualification is SYNC_STAGES+1 cycles.
- States: IDLE, PRE, WAIT_TRIG, CAPTURE, DONE.
- IDLE, DONE: on arm, latch pretrig_samples and total_samples, clear done, overflow, samples_captured, trig_index and trig_status, and go to PRE. capture_go rises the cycle after arm.
- Any arm in PRE, WAIT_TRIG or CAPTURE is ignored.
- PRE: capture_go=1, samples_captured increments every cycle, and triggers are ignored. Go to WAIT_TRIG when samples_captured+1 == latched pretrig. If latched pretrig=0, go from the arm cycle directly to WAIT_TRIG.
- WAIT_TRIG: capture_go=1 and counting continues. On a qualified trigger: trig_index <= samples_captured, trig_status <= 1, go to CAPTURE. No timeout.
- CAPTURE: counting continues. Go to DONE when samples_captured+1 == latched total, or when dp_stop=1, whichever comes first.
- Entering DONE: capture_go, trig_status and busy fall on the same edge, and done rises.
- Degenerate totals: if latched total == 0, go from arm straight to DONE with capture_go never asserted. If total <= pretrig, end in PRE when the count reaches total; trig_index stays 0 and trig_status is never set.
- Overflow: fifo_full=1 while capture_go=1 sets overflow and forces DONE on the next edge, from any active state.
- Abort: from any active state, next state is IDLE with capture_go, trig_status and busy cleared. done and overflow are not set. Counters freeze.
- Simultaneous events, by priority: abort > overflow > dp_stop > count-reached > trigger.
- samples_captured saturates at all-ones and never wraps. The latched total is compared exactly.
- Reset mid-capture: capture_go drops asynchronously. The datapath re-initialises on capture_go low.

Decomposition:
- Shared package: state encoding constants (IDLE..DONE) and trig_mode encodings (TRIG_RISE, TRIG_FALL, TRIG_HIGH, TRIG_LOW).
- One sub-module, trig_qualifier: the synchronizer, edge detect and mode select, producing a one-cycle or level trig_hit.

Test Plan:
- pretrig=10, total=100, rising mode, trig_in rises at arm+40 -> capture_go high for exactly 100 cycles; trig_index=40±(SYNC_STAGES+1); done=1; overflow=0.
- Trigger pulse at arm+5 with pretrig=10, then a second rising edge at arm+30 -> the first is ignored; trig_index reflects the second edge.
- Falling mode, total=50; fifo_full pulsed at arm+20 -> overflow=1, done=1, capture_go low at arm+22, samples_captured~21.
- High-level mode with trig_in already high, pretrig=0 -> trigger accepted immediately after synchronizer latency; dp_stop at arm+30 ends the capture; done=1.
- abort at arm+15 -> capture_go low next cycle; done=0; busy=0. Re-arm succeeds and counters clear.
- total=0 -> arm goes straight to DONE with capture_go never high. total=5, pretrig=8 -> done after 5 samples, trig_status never set.
